// File: rtl/dds_pkg.sv
// dds_pkg
//   Shared types and constants for the DDS PWM link.
//   - DEFAULT_PWM_BITS : default sample width; a nominal PWM frame is 2^bits clocks
//   - demod_state_t    : pwm_demodulator FSM states
//   - NOMINAL_PERIOD   : expected frame length at the default width
//   - TIMEOUT          : clocks without a rising edge before the line is declared stuck
package dds_pkg;

  localparam int DEFAULT_PWM_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } demod_state_t;

  // Frame length for a given sample width.
  function automatic int nominal_period(input int bits);
    return 1 << bits;
  endfunction

  // Largest value of the (bits+1)-wide period counter.
  function automatic int timeout_count(input int bits);
    return (1 << (bits + 1)) - 1;
  endfunction

  localparam int NOMINAL_PERIOD = nominal_period(DEFAULT_PWM_BITS);
  localparam int TIMEOUT        = timeout_count(DEFAULT_PWM_BITS);

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous level into the clock domain and flags its rising edges.
//   Also reused for the push-button inputs of input_controller.
//   Ports:
//     clock  - system clock
//     reset  - asynchronous, active-low reset
//     din    - asynchronous input level
//     s      - synchronised level, time-aligned with rise
//     rise   - one-cycle pulse on each 0->1 transition of s
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  // The synchroniser chain shifts din in at the bottom; its top bit is the
  // first metastability-safe copy. The edge flag is registered rather than
  // decoded combinationally so downstream logic sees a clean flop output,
  // and the level we hand out is the delayed copy so it lines up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_d <= sync_q[SYNC_STAGES-1];
      rise    <= sync_q[SYNC_STAGES-1] & ~level_d;
    end
  end

  assign s = level_d;

endmodule

// File: rtl/pwm_demodulator.sv
// pwm_demodulator
//   Receive end of the DDS PWM link. Measures the high time and the period of
//   every PWM frame and emits one reconstructed sample per frame.
//   Ports:
//     clock        - system clock (100 MHz)
//     reset        - asynchronous, active-low reset
//     enable       - 1 = measure; 0 = idle with counters cleared
//     pwm_in       - asynchronous PWM bitstream
//     sample       - high-cycle count of the last complete frame (saturating)
//     sample_valid - one-cycle strobe, coincident with sample/period_meas updates
//     period_meas  - clocks between the last two rising edges (saturating)
//     period_err   - last period_meas differed from the nominal frame length
//     stuck        - no rising edge seen for the timeout interval
module pwm_demodulator
  import dds_pkg::*;
#(
  parameter int PWM_BITS    = DEFAULT_PWM_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_in,
  output logic [PWM_BITS-1:0] sample,
  output logic                sample_valid,
  output logic [PWM_BITS:0]   period_meas,
  output logic                period_err,
  output logic                stuck
);

  localparam int                NOMINAL_INT = nominal_period(PWM_BITS);
  localparam int                TIMEOUT_INT = timeout_count(PWM_BITS);
  localparam logic [PWM_BITS:0] NOMINAL_CNT = NOMINAL_INT[PWM_BITS:0];
  localparam logic [PWM_BITS:0] TIMEOUT_CNT = TIMEOUT_INT[PWM_BITS:0];
  localparam logic [PWM_BITS-1:0] HI_MAX    = '1;

  logic                s;
  logic                rise;
  logic [PWM_BITS:0]   tot_cnt;
  logic [PWM_BITS-1:0] hi_cnt;
  demod_state_t        state;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clock(clock),
    .reset(reset),
    .din  (pwm_in),
    .s    (s),
    .rise (rise)
  );

  // Frame counters. A rising edge starts a new frame and counts itself as the
  // first clock (and first high clock) of that frame, so at the next edge the
  // counters hold exactly the period and high time. Both saturate rather than
  // wrap so a dead line never aliases into a plausible measurement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tot_cnt <= '0;
      hi_cnt  <= '0;
    end else if (!enable) begin
      tot_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      tot_cnt <= (PWM_BITS+1)'(1);
      hi_cnt  <= PWM_BITS'(1);
    end else begin
      if (tot_cnt != TIMEOUT_CNT) begin
        tot_cnt <= tot_cnt + 1'b1;
      end
      if (s && (hi_cnt != HI_MAX)) begin
        hi_cnt <= hi_cnt + 1'b1;
      end
    end
  end

  // Control FSM with registered outputs. IDLE throws away the partial frame
  // that precedes the first observed edge. In MEASURE each edge publishes the
  // frame just finished; a rise on the same cycle the counter tops out is still
  // a valid frame, so the rise check comes first. Timing out reports the
  // current line level as a full-scale or zero sample and parks in STUCK until
  // the line moves again; that recovering edge only restarts measurement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sample       <= '0;
      sample_valid <= 1'b0;
      period_meas  <= '0;
      period_err   <= 1'b0;
      stuck        <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      sample_valid <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            sample       <= hi_cnt;
            period_meas  <= tot_cnt;
            period_err   <= (tot_cnt != NOMINAL_CNT);
            sample_valid <= 1'b1;
          end else if (tot_cnt == TIMEOUT_CNT) begin
            state        <= STUCK;
            sample       <= s ? HI_MAX : '0;
            period_meas  <= '0;
            period_err   <= 1'b1;
            sample_valid <= 1'b1;
            stuck        <= 1'b1;
          end
        end
        STUCK: begin
          if (rise) begin
            state <= MEASURE;
            stuck <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
